key_event_queue: RTL and testbench

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/key_event_queue_pkg.sv | 25 ++
 rtl/key_event_queue_if.sv | 15 +
 rtl/key_evt_fifo.sv | 51 +++++
 rtl/key_event_queue.sv | 139 +++++++++++++
 tb/tb_key_event_queue.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/key_event_queue_pkg.sv
// Shared event encoding for the key event queue: bit positions, empty marker, event record.
package keyevt_pkg;

  localparam int unsigned EVT_W      = 8;
  localparam int unsigned EVT_PRESS  = 7;
  localparam int unsigned EVT_REPEAT = 6;
  localparam logic [EVT_W-1:0] EVT_EMPTY = 8'hFF;

  typedef struct packed {
    logic       press;
    logic       rpt;
    logic       rsvd;
    logic [4:0] key;
  } key_evt_t;

  function automatic key_evt_t make_evt(input logic p, input logic r, input logic [4:0] k);
    key_evt_t e;
    e.press = p;
    e.rpt   = r;
    e.rsvd  = 1'b0;
    e.key   = k;
    return e;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Scan input / event output bundle between the keypad scanner, the queue and its consumer.
interface key_event_queue_if #(
  parameter int unsigned NKEY = 20
);
  logic            KEY_TICK;
  logic [NKEY-1:0] KEY_RAW;
  logic            POP;
  logic [7:0]      EVT;
  logic            EMPTY;
  logic [3:0]      COUNT;
  logic            INT;

  modport slave  (input KEY_TICK, KEY_RAW, POP, output EVT, EMPTY, COUNT, INT);
  modport master (output KEY_TICK, KEY_RAW, POP, input EVT, EMPTY, COUNT, INT);
endinterface

// File: rtl/key_evt_fifo.sv
// Event FIFO: power-of-two depth, head visible combinationally, EVT_EMPTY shown when empty.
module key_evt_fifo
  import keyevt_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  key_evt_t      din,
  output logic [7:0]    data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign data    = empty ? EVT_EMPTY : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Debounced key matrix to press/release event queue. Define KEYEVT_REPEAT_EN to build in auto-repeat.
module key_event_queue
  import keyevt_pkg::*;
#(
  parameter int unsigned NKEY      = 20,
  parameter int unsigned DEB_TICKS = 4,
  parameter int unsigned DEPTH     = 8
`ifdef KEYEVT_REPEAT_EN
  ,
  parameter int unsigned REP_DELAY = 12500,
  parameter int unsigned REP_RATE  = 2500
`endif
) (
  input logic             CLK,
  input logic             RST,
  key_event_queue_if.slave bus
);

  localparam int unsigned DCW = $clog2(DEB_TICKS) + 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  logic [NKEY-1:0] last_q, stable_q, reported_q;
  logic [NKEY-1:0] pending, pend_mask;
  logic [DCW-1:0]  deb_q, deb_nxt;
  logic [4:0]      pend_idx;
  logic            pend_any, pend_press, pend_push;
  logic            push, full, empty;
  key_evt_t        din, pend_evt;
  logic [CW-1:0]   count;

  // One shared counter: any change in the raw vector restarts the stability window
  always_comb begin
    deb_nxt = deb_q;
    if (bus.KEY_RAW != last_q)                deb_nxt = '0;
    else if (deb_q != DCW'(DEB_TICKS - 1))    deb_nxt = DCW'(deb_q + 1'b1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q   <= '1;
      stable_q <= '1;
      deb_q    <= '0;
    end else if (bus.KEY_TICK) begin
      last_q <= bus.KEY_RAW;
      deb_q  <= deb_nxt;
      if (deb_nxt == DCW'(DEB_TICKS - 1)) stable_q <= bus.KEY_RAW;
    end
  end

  // Lowest pending index wins; descending scan leaves it as the final assignment
  always_comb begin
    pending    = stable_q ^ reported_q;
    pend_any   = |pending;
    pend_idx   = '0;
    pend_press = 1'b0;
    pend_mask  = '0;
    for (int i = int'(NKEY) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pend_idx   = 5'(i);
        pend_press = ~stable_q[i];
        pend_mask  = '0;
        pend_mask[i] = 1'b1;
      end
    end
    pend_push = pend_any & ~full;
    pend_evt  = make_evt(pend_press, 1'b0, pend_idx);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            reported_q <= '1;
    else if (pend_push) reported_q <= reported_q ^ pend_mask;
  end

`ifdef KEYEVT_REPEAT_EN
  localparam int unsigned RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned RW   = $clog2(RMAX) + 1;

  logic [RW-1:0] rep_q;
  logic          rep_first_q, rep_arm, rep_fire;
  logic [5:0]    n_down;
  logic [4:0]    down_idx;

  // Armed only with a single held key and nothing pending; a STABLE change always disarms
  always_comb begin
    n_down   = '0;
    down_idx = '0;
    for (int i = int'(NKEY) - 1; i >= 0; i--) begin
      if (!stable_q[i]) begin
        n_down   = 6'(n_down + 1'b1);
        down_idx = 5'(i);
      end
    end
    rep_arm  = (n_down == 6'd1) & ~pend_any;
    rep_fire = rep_arm & bus.KEY_TICK &
               (rep_q == (rep_first_q ? RW'(REP_DELAY - 1) : RW'(REP_RATE - 1)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else if (!rep_arm) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else if (bus.KEY_TICK) begin
      if (rep_fire) begin
        rep_q       <= '0;
        rep_first_q <= 1'b0;
      end else begin
        rep_q <= RW'(rep_q + 1'b1);
      end
    end
  end

  // Repeats are dropped rather than stalled when the queue is full
  assign push = pend_push | (rep_fire & ~full);
  assign din  = pend_any ? pend_evt : make_evt(1'b1, 1'b1, down_idx);
`else
  assign push = pend_push;
  assign din  = pend_evt;
`endif

  key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (bus.POP),
    .din   (din),
    .data  (bus.EVT),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign bus.EMPTY = empty;
  assign bus.COUNT = 4'(count);
  assign bus.INT   = empty;

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: vector table plus hand sequences, scoreboard-ordered events.
module tb_key_event_queue;

  localparam logic [19:0] ONES = 20'hFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_event_queue_if #(.NKEY(20)) kif ();

  key_event_queue #(.NKEY(20), .DEB_TICKS(4), .DEPTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (kif.slave)
  );

  typedef struct packed {
    logic [19:0] raw;
    logic [7:0]  ticks;
    logic [2:0]  n;
    logic [31:0] evs;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick(input logic [19:0] raw);
    @(negedge clk);
    kif.KEY_RAW  = raw;
    kif.KEY_TICK = 1'b1;
    @(negedge clk);
    kif.KEY_TICK = 1'b0;
  endtask

  task automatic ticks(input logic [19:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(raw);
  endtask

  task automatic pop_once();
    @(negedge clk);
    kif.POP = 1'b1;
    @(negedge clk);
    kif.POP = 1'b0;
  endtask

  task automatic check_idle(input string name);
    repeat (3) @(negedge clk);
    check({name, "_empty"}, 32'(kif.EMPTY), 32'd1);
    check({name, "_int"},   32'(kif.INT),   32'd1);
    check({name, "_count"}, 32'(kif.COUNT), 32'd0);
    check({name, "_evt"},   32'(kif.EVT),   32'hFF);
  endtask

  // Pop every scoreboard entry in order, comparing the head before each POP
  task automatic drain(input string name);
    logic [7:0] e;
    bit found;
    while (exp_q.size() > 0) begin
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (!kif.EMPTY) begin found = 1'b1; break; end
        @(negedge clk);
      end
      e = exp_q.pop_front();
      if (!found) begin
        n_total++;
        $display("FAIL %s_timeout: got no event, want %0h", name, e);
        exp_q.delete();
      end else begin
        check({name, "_evt"}, 32'(kif.EVT), 32'(e));
        check({name, "_int_low"}, 32'(kif.INT), 32'd0);
        pop_once();
      end
    end
    check_idle(name);
  endtask

  initial begin
    logic [7:0] ev;
    int n;
    kif.KEY_TICK = 1'b0;
    kif.KEY_RAW  = ONES;
    kif.POP      = 1'b0;

    vecs[0] = '{raw: 20'hFFFF7, ticks: 8'd4, n: 3'd1, evs: 32'h0000_0083};
    vecs[1] = '{raw: 20'hFFDFB, ticks: 8'd4, n: 3'd2, evs: 32'h0000_8982};
    vecs[2] = '{raw: 20'hFFFFE, ticks: 8'd4, n: 3'd1, evs: 32'h0000_0080};
    vecs[3] = '{raw: 20'h7FFFF, ticks: 8'd4, n: 3'd1, evs: 32'h0000_0093};
    vecs[4] = '{raw: 20'hDFFEF, ticks: 8'd4, n: 3'd2, evs: 32'h0000_9184};
    vecs[5] = '{raw: 20'hFFFF7, ticks: 8'd3, n: 3'd0, evs: 32'h0000_0000};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // Table: press pattern, check push cadence, drain; then release and drain
    for (int v = 0; v < 6; v++) begin
      ticks(vecs[v].raw, int'(vecs[v].ticks));
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk);
        check($sformatf("v%0d_ramp%0d", v, k), 32'(kif.COUNT),
              32'((k < int'(vecs[v].n)) ? k : int'(vecs[v].n)));
      end
      for (int k = 0; k < int'(vecs[v].n); k++) exp_q.push_back(vecs[v].evs[8*k +: 8]);
      drain($sformatf("v%0d_press", v));
      ticks(ONES, 4);
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        ev = vecs[v].evs[8*k +: 8];
        exp_q.push_back(ev & 8'h7F);
      end
      drain($sformatf("v%0d_release", v));
    end

    // Full queue stalls key 5; key 6 toggling twice while stalled yields nothing
    ticks(20'hFFFF0, 4);
    ticks(ONES, 4);
    foreach (exp_q[i]) ;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h80 + k));
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(k));
    repeat (5) @(negedge clk);
    check("full_count", 32'(kif.COUNT), 32'd8);
    ticks(20'hFFFDF, 4);
    repeat (3) @(negedge clk);
    check("stall_count", 32'(kif.COUNT), 32'd8);
    ticks(20'hFFF9F, 4);
    ticks(20'hFFFDF, 4);
    check("stall_head", 32'(kif.EVT), 32'(exp_q.pop_front()));
    pop_once();
    repeat (2) @(negedge clk);
    check("refill_count", 32'(kif.COUNT), 32'd8);
    exp_q.push_back(8'h85);
    drain("full_drain");
    ticks(ONES, 4);
    exp_q.push_back(8'h05);
    drain("full_release");

    // Push and POP on the same edge at COUNT=3
    ticks(20'hFE3FF, 4);
    repeat (4) @(negedge clk);
    check("c3_count", 32'(kif.COUNT), 32'd3);
    exp_q.push_back(8'h8A); exp_q.push_back(8'h8B); exp_q.push_back(8'h8C);
    ticks(20'hFC3FF, 4);
    check("c3_head", 32'(kif.EVT), 32'(exp_q.pop_front()));
    kif.POP = 1'b1;
    @(negedge clk);
    kif.POP = 1'b0;
    check("c3_same_edge", 32'(kif.COUNT), 32'd3);
    exp_q.push_back(8'h8D);
    drain("c3_drain");
    pop_once();
    check("pop_empty_count", 32'(kif.COUNT), 32'd0);
    check("pop_empty_flag", 32'(kif.EMPTY), 32'd1);
    ticks(ONES, 4);
    for (int k = 10; k < 14; k++) exp_q.push_back(8'(k));
    drain("c3_release");

    // Reset mid-operation discards queued and pending events
    ticks(20'hFFFF9, 4);
    @(negedge clk);
    check("pre_rst_count", 32'(kif.COUNT), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_count", 32'(kif.COUNT), 32'd0);
    check("rst_async_evt", 32'(kif.EVT), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("post_rst");
    ticks(ONES, 4);
    check_idle("post_rst_release");

`ifdef KEYEVT_REPEAT_EN
    // Auto-repeat on a single held key
    ticks(20'hFFFFE, 4);
    exp_q.push_back(8'h80);
    drain("rep_press");
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (n < 13000) begin
        tick(20'hFFFFE);
        n++;
        if (!kif.EMPTY) break;
      end
      check($sformatf("rep%0d_ticks", r), 32'(n), (r == 0) ? 32'd12500 : 32'd2500);
      exp_q.push_back(8'hC0);
      drain($sformatf("rep%0d", r));
    end
    ticks(ONES, 4);
    exp_q.push_back(8'h00);
    drain("rep_release");
    ticks(ONES, 100);
    check_idle("rep_stopped");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
